// File: rtl/alu_pipe_n.sv
// Two-stage pipelined N-bit ALU with valid/ready on both sides and a
// persistent carry/borrow register so ADC/SBC chain across beats.
module alu_pipe_n #(
  parameter int WIDTH       = 4,
  parameter bit PARITY_EVEN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             clr_cb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cf,
  output logic             bf,
  output logic             vf,
  output logic             zf,
  output logic             sf,
  output logic             pf
);
  localparam int W = WIDTH;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_ADC = 4'h2, OP_SBC = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                         OP_SHL = 4'h8, OP_SHR = 4'h9, OP_SAR = 4'hA, OP_ROL = 4'hB,
                         OP_ROR = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_CMP = 4'hF;

  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic         clr_q, clr_d, s1_valid_q, s1_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] y_q, y_d;
  logic [5:0]   flg_q, flg_d;
  logic         cf_q, cf_d, bf_q, bf_d;
  logic         s2_adv, accept;

  logic [W-1:0] add_b, sub_b, r_y;
  logic         add_c, sub_c, add_v, sub_v, cin, bin;
  logic [W:0]   sum, dif;
  logic         r_cf, r_bf, r_vf, r_zf, r_sf, r_pf;

  assign s2_adv   = s1_valid_q & (!out_valid_q | out_ready);
  assign in_ready = !rst & (!s1_valid_q | s2_adv);
  assign accept   = in_valid & in_ready;

  // One adder and one subtractor shared by all arithmetic ops.
  always_comb begin
    cin   = cf_q & !clr_q;
    bin   = bf_q & !clr_q;
    add_b = b_q;
    add_c = 1'b0;
    sub_b = b_q;
    sub_c = 1'b0;
    if (op_q == OP_ADC) add_c = cin;
    if (op_q == OP_INC) begin add_b = '0; add_c = 1'b1; end
    if (op_q == OP_SBC) sub_c = bin;
    if (op_q == OP_DEC) begin sub_b = '0; sub_c = 1'b1; end
    sum   = {1'b0, a_q} + {1'b0, add_b} + {{W{1'b0}}, add_c};
    dif   = {1'b0, a_q} - {1'b0, sub_b} - {{W{1'b0}}, sub_c};
    add_v = (a_q[W-1] == add_b[W-1]) & (sum[W-1] != a_q[W-1]);
    sub_v = (a_q[W-1] != sub_b[W-1]) & (dif[W-1] != a_q[W-1]);

    r_y  = '0;
    r_cf = 1'b0;
    r_bf = 1'b0;
    r_vf = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_INC: begin r_y = sum[W-1:0]; r_cf = sum[W]; r_vf = add_v; end
      OP_SUB, OP_SBC, OP_DEC: begin r_y = dif[W-1:0]; r_bf = dif[W]; r_vf = sub_v; end
      OP_AND: r_y = a_q & b_q;
      OP_OR:  r_y = a_q | b_q;
      OP_XOR: r_y = a_q ^ b_q;
      OP_NOT: r_y = ~a_q;
      OP_SHL: begin r_y = {a_q[W-2:0], 1'b0};     r_cf = a_q[W-1]; end
      OP_SHR: begin r_y = {1'b0, a_q[W-1:1]};     r_cf = a_q[0];   end
      OP_SAR: begin r_y = {a_q[W-1], a_q[W-1:1]}; r_cf = a_q[0];   end
      OP_ROL: begin r_y = {a_q[W-2:0], a_q[W-1]}; r_cf = a_q[W-1]; end
      OP_ROR: begin r_y = {a_q[0], a_q[W-1:1]};   r_cf = a_q[0];   end
      default: begin r_y = a_q; r_bf = dif[W]; r_vf = sub_v; end
    endcase
    r_zf = (op_q == OP_CMP) ? (a_q == b_q) : (r_y == '0);
    r_sf = (op_q == OP_CMP) ? dif[W-1] : r_y[W-1];
    r_pf = PARITY_EVEN ? ~^r_y : ^r_y;
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    clr_d       = clr_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    flg_d       = flg_q;
    cf_d        = cf_q;
    bf_d        = bf_q;
    if (accept) begin
      a_d        = a;
      b_d        = b;
      op_d       = op;
      clr_d      = clr_cb;
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    // Carry/borrow store moves with the S1->S2 transfer so chained beats see it.
    if (s2_adv) begin
      out_valid_d = 1'b1;
      y_d         = r_y;
      flg_d       = {r_cf, r_bf, r_vf, r_zf, r_sf, r_pf};
      cf_d        = r_cf;
      bf_d        = r_bf;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      clr_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flg_q       <= '0;
      cf_q        <= 1'b0;
      bf_q        <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      clr_q       <= clr_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flg_q       <= flg_d;
      cf_q        <= cf_d;
      bf_q        <= bf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cf        = flg_q[5];
  assign bf        = flg_q[4];
  assign vf        = flg_q[3];
  assign zf        = flg_q[2];
  assign sf        = flg_q[1];
  assign pf        = flg_q[0];
endmodule
